snoop_bus_arbiter: RTL



---
 rtl/snoop_bus_arbiter.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/snoop_bus_arbiter.sv
// Two-core snoop-bus arbiter: per-core request FIFOs, round-robin grant, one-cycle broadcast to the other core.
// Optional BUS_STATS_EN adds saturating per-command grant counters and a drop counter.
module snoop_bus_arbiter #(
  parameter int ADDR_BITS  = 11,
  parameter int DATA_BITS  = 16,
  parameter int FIFO_DEPTH = 2,
  parameter int PTR_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           req0_cmd,
  input  logic [ADDR_BITS-1:0] req0_addr,
  input  logic [DATA_BITS-1:0] req0_data,
  input  logic [1:0]           req1_cmd,
  input  logic [ADDR_BITS-1:0] req1_addr,
  input  logic [DATA_BITS-1:0] req1_data,
  output logic [1:0]           snoop0_cmd,
  output logic [ADDR_BITS-1:0] snoop0_addr,
  output logic [DATA_BITS-1:0] snoop0_data,
  output logic [1:0]           snoop1_cmd,
  output logic [ADDR_BITS-1:0] snoop1_addr,
  output logic [DATA_BITS-1:0] snoop1_data,
  output logic [1:0]           grant,
  output logic [1:0]           fifo_full,
  output logic                 o_dbg_state,
  output logic [1:0]           overflow
`ifdef BUS_STATS_EN
  ,
  output logic [15:0]          stat_rd,
  output logic [15:0]          stat_wr,
  output logic [15:0]          stat_upd,
  output logic [7:0]           stat_drop
`endif
);

  localparam int EW = 2 + ADDR_BITS + DATA_BITS;
  localparam logic [PTR_BITS:0] FULL_CNT = (PTR_BITS + 1)'(FIFO_DEPTH);

  typedef enum logic {S_IDLE = 1'b0, S_BCAST = 1'b1} state_t;
  state_t r_state, w_state_nxt;

  // Handshake: reqK_cmd != 00 is a valid with no ready; it is always taken, or dropped
  // (flagged in overflow) when FIFO K is full and not popped. grant[k] is the output valid.
  logic [EW-1:0]       w_req [2];
  logic [EW-1:0]       r_mem [2][FIFO_DEPTH];
  logic [PTR_BITS-1:0] r_wptr [2];
  logic [PTR_BITS-1:0] r_rptr [2];
  logic [PTR_BITS:0]   r_cnt [2];
  logic [PTR_BITS:0]   w_cnt_nxt [2];
  logic [1:0]          w_push, w_accept, w_drop, w_pop;
  logic                w_win;
  logic [EW-1:0]       w_head;
  logic                r_last;
  logic [1:0]          r_full, r_ovf, r_grant;
  logic [1:0]          r_s0_cmd, r_s1_cmd;
  logic [ADDR_BITS-1:0] r_s0_addr, r_s1_addr;
  logic [DATA_BITS-1:0] r_s0_data, r_s1_data;

  assign w_req[0] = {req0_cmd, req0_addr, req0_data};
  assign w_req[1] = {req1_cmd, req1_addr, req1_data};
  assign w_head   = r_mem[w_win][r_rptr[w_win]];

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      w_push[k]    = (w_req[k][EW-1 -: 2] != 2'b00);
      w_accept[k]  = w_push[k] && ((r_cnt[k] != FULL_CNT) || w_pop[k]);
      w_drop[k]    = w_push[k] && !w_accept[k];
      w_cnt_nxt[k] = r_cnt[k] + (PTR_BITS + 1)'(w_accept[k]) - (PTR_BITS + 1)'(w_pop[k]);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 2'b00;
    w_win       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if ((r_cnt[0] != '0) || (r_cnt[1] != '0)) begin
          if ((r_cnt[0] != '0) && (r_cnt[1] != '0)) w_win = ~r_last;
          else                                      w_win = (r_cnt[1] != '0);
          w_pop[w_win] = 1'b1;
          w_state_nxt  = S_BCAST;
        end
      end
      S_BCAST: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (w_accept[k]) r_mem[k][r_wptr[k]] <= w_req[k];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        r_wptr[k] <= '0;
        r_rptr[k] <= '0;
        r_cnt[k]  <= '0;
      end
      r_full <= 2'b00;
      r_ovf  <= 2'b00;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (w_accept[k]) r_wptr[k] <= r_wptr[k] + PTR_BITS'(1);
        if (w_pop[k])    r_rptr[k] <= r_rptr[k] + PTR_BITS'(1);
        r_cnt[k]  <= w_cnt_nxt[k];
        r_full[k] <= (w_cnt_nxt[k] == FULL_CNT);
        if (w_drop[k]) r_ovf[k] <= 1'b1;
      end
    end
  end

  // Address/data are left holding after a broadcast; only cmd and grant return to zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last    <= 1'b1;
      r_grant   <= 2'b00;
      r_s0_cmd  <= 2'b00;
      r_s0_addr <= '0;
      r_s0_data <= '0;
      r_s1_cmd  <= 2'b00;
      r_s1_addr <= '0;
      r_s1_data <= '0;
    end else if (r_state == S_BCAST) begin
      r_grant  <= 2'b00;
      r_s0_cmd <= 2'b00;
      r_s1_cmd <= 2'b00;
    end else if (w_pop != 2'b00) begin
      r_grant <= w_pop;
      r_last  <= w_win;
      if (!w_win) {r_s1_cmd, r_s1_addr, r_s1_data} <= w_head;
      else        {r_s0_cmd, r_s0_addr, r_s0_data} <= w_head;
    end
  end

  assign snoop0_cmd  = r_s0_cmd;
  assign snoop0_addr = r_s0_addr;
  assign snoop0_data = r_s0_data;
  assign snoop1_cmd  = r_s1_cmd;
  assign snoop1_addr = r_s1_addr;
  assign snoop1_data = r_s1_data;
  assign grant       = r_grant;
  assign fifo_full   = r_full;
  assign overflow    = r_ovf;
  assign o_dbg_state = (r_state == S_BCAST);

`ifdef BUS_STATS_EN
  logic [15:0] r_stat_rd, r_stat_wr, r_stat_upd;
  logic [7:0]  r_stat_drop;
  logic [8:0]  w_drop_sum;

  assign w_drop_sum = {1'b0, r_stat_drop} + 9'(w_drop[0]) + 9'(w_drop[1]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stat_rd   <= '0;
      r_stat_wr   <= '0;
      r_stat_upd  <= '0;
      r_stat_drop <= '0;
    end else begin
      if (w_pop != 2'b00) begin
        case (w_head[EW-1 -: 2])
          2'b01:   if (r_stat_rd  != '1) r_stat_rd  <= r_stat_rd + 16'd1;
          2'b10:   if (r_stat_wr  != '1) r_stat_wr  <= r_stat_wr + 16'd1;
          2'b11:   if (r_stat_upd != '1) r_stat_upd <= r_stat_upd + 16'd1;
          default: ;
        endcase
      end
      r_stat_drop <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
    end
  end

  assign stat_rd   = r_stat_rd;
  assign stat_wr   = r_stat_wr;
  assign stat_upd  = r_stat_upd;
  assign stat_drop = r_stat_drop;
`endif

endmodule
